// File: rtl/seg_data_formatter_if.sv
// Bus between the MMIO write decode (master) and seg_data_formatter (slave).
// seg_data feeds the seven-segment driver's seg_in.
interface seg_data_formatter_if #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 8
);
    logic                  wr_en;
    logic [BIN_W-1:0]      wr_data;
    logic                  dec_mode;
    logic                  ready;
    logic                  done;
    logic [4*DIGITS-1:0]   seg_data;

    modport master (
        output wr_en, wr_data, dec_mode,
        input  ready, done, seg_data
    );

    modport slave (
        input  wr_en, wr_data, dec_mode,
        output ready, done, seg_data
    );
endinterface

// File: rtl/seg_data_formatter.sv
// Turns an MMIO write into packed display nibbles: hex passthrough or iterative double-dabble BCD.
// Optional feature macro SEG_SIGNED_EN: signed decimal with a leading '-' (4'hF) digit.
module seg_data_formatter #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    seg_data_formatter_if.slave bus
);
    localparam int SEG_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0]      MAX_UNS = pow10(DIGITS) - 64'd1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(BIN_W - 1);

    logic [1:0]       state_q, state_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [SEG_W-1:0] bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [SEG_W-1:0] adj;
    logic [BIN_W-1:0] mag;
    logic             ovf;

`ifdef SEG_SIGNED_EN
    localparam logic [63:0] MAX_SGN = pow10(DIGITS - 1) - 64'd1;
    logic neg_q, neg_d;
    logic neg;

    // The most-negative input negates to itself and lands far above MAX_SGN, so it overflows naturally.
    always_comb begin
        neg = bus.wr_data[BIN_W-1];
        mag = neg ? (-bus.wr_data) : bus.wr_data;
        ovf = neg ? (64'(mag) > MAX_SGN) : (64'(bus.wr_data) > MAX_UNS);
    end
`else
    always_comb begin
        mag = bus.wr_data;
        ovf = 64'(bus.wr_data) > MAX_UNS;
    end
`endif

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        adj     = bcd_q;
`ifdef SEG_SIGNED_EN
        neg_d   = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.wr_en) begin
                    if (!bus.dec_mode) begin
                        seg_d  = SEG_W'(bus.wr_data);
                        done_d = 1'b1;
                    end else if (ovf) begin
                        seg_d  = '1;
                        done_d = 1'b1;
                    end else begin
                        bin_d   = mag;
                        bcd_d   = '0;
                        cnt_d   = '0;
                        state_d = CONV;
`ifdef SEG_SIGNED_EN
                        neg_d   = neg;
`endif
                    end
                end
            end
            CONV: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
                end
                // The BCD MSB falls off here; the range check keeps it zero.
                {bcd_d, bin_d} = {adj[SEG_W-2:0], bin_q, 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = LOAD;
            end
            LOAD: begin
                seg_d = bcd_q;
`ifdef SEG_SIGNED_EN
                if (neg_q) seg_d[SEG_W-1 -: 4] = 4'hF;
`endif
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            seg_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef SEG_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef SEG_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

    assign bus.ready    = (state_q == IDLE);
    assign bus.done     = done_q;
    assign bus.seg_data = seg_q;
endmodule

// File: tb/tb_seg_data_formatter.sv
// Self-checking bench for seg_data_formatter: vector table, random writes against a
// decimal-arithmetic reference model, and hand-written busy/reset sequences.
module tb_seg_data_formatter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_data_formatter_if #(.BIN_W(32), .DIGITS(8)) bus();

    seg_data_formatter #(.BIN_W(32), .DIGITS(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        dec;
        logic [31:0] exp;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] toBcd(input int unsigned v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] model(input logic [31:0] d, input logic dec);
        logic [31:0] r;
        int unsigned m;
        if (!dec) return d;
`ifdef SEG_SIGNED_EN
        if (d[31]) begin
            m = -d;
            if (m > 32'd9999999) return 32'hFFFFFFFF;
            r = toBcd(m);
            r[31:28] = 4'hF;
            return r;
        end
`endif
        m = d;
        if (m > 32'd99999999) return 32'hFFFFFFFF;
        r = toBcd(m);
        return r;
    endfunction

    // One write, then wait (bounded) for done; checks latency, busy time, value, pulse width.
    task automatic applyStimulus(input logic [31:0] d, input logic dec, input logic [31:0] exp, input string name);
        int lat;
        int lowCnt;
        int expLat;
        expLat = (!dec || exp == 32'hFFFFFFFF) ? 1 : 34;
        @(negedge clk);
        checkOutput({name, " ready_before"}, 32'(bus.ready), 32'd1);
        bus.wr_en    = 1'b1;
        bus.wr_data  = d;
        bus.dec_mode = dec;
        @(negedge clk);
        bus.wr_en = 1'b0;
        lat = 1;
        lowCnt = 0;
        while (!bus.done && lat < 40) begin
            if (!bus.ready) lowCnt++;
            @(negedge clk);
            lat++;
        end
        checkOutput({name, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({name, " busy_cycles"}, 32'(lowCnt), (expLat == 1) ? 32'd0 : 32'd33);
        checkOutput({name, " seg_data"}, bus.seg_data, exp);
        checkOutput({name, " ready_at_done"}, 32'(bus.ready), 32'd1);
        @(negedge clk);
        checkOutput({name, " done_width"}, 32'(bus.done), 32'd0);
        checkOutput({name, " seg_hold"}, bus.seg_data, exp);
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] prev;
        logic [31:0] d;
        logic        dec;
        int          lat;
        int          doneSeen;

        vecs.push_back('{32'h1234ABCD, 1'b0, 32'h1234ABCD});
        vecs.push_back('{32'd12345678, 1'b1, 32'h12345678});
        vecs.push_back('{32'd100000000, 1'b1, 32'hFFFFFFFF});
        vecs.push_back('{32'd99999999, 1'b1, 32'h99999999});
        vecs.push_back('{32'd0, 1'b1, 32'h00000000});
        vecs.push_back('{32'd9, 1'b1, 32'h00000009});
        vecs.push_back('{32'd10, 1'b1, 32'h00000010});
        vecs.push_back('{32'd1000, 1'b1, 32'h00001000});
        vecs.push_back('{32'd10000000, 1'b1, 32'h10000000});
        vecs.push_back('{32'h7FFFFFFF, 1'b1, 32'hFFFFFFFF});
        vecs.push_back('{32'h00000000, 1'b0, 32'h00000000});
        vecs.push_back('{32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF});

        // Reset must win over a simultaneous write.
        rst          = 1'b1;
        bus.wr_en    = 1'b1;
        bus.wr_data  = 32'hDEAD;
        bus.dec_mode = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset seg_data", bus.seg_data, 32'h0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset ready", 32'(bus.ready), 32'd1);
        rst       = 1'b0;
        bus.wr_en = 1'b0;

        foreach (vecs[i]) applyStimulus(vecs[i].data, vecs[i].dec, vecs[i].exp, $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: d = $urandom_range(0, 99999999);
                1: d = $urandom_range(0, 999);
                2: d = $urandom;
                default: d = 32'd100000000 + $urandom_range(0, 3) - 32'd2;
            endcase
            dec = ($urandom_range(0, 3) != 0);
            applyStimulus(d, dec, model(d, dec), $sformatf("rand%0d", i));
        end

        // Write during conversion is dropped; display holds the old value meanwhile.
        prev = bus.seg_data;
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_data = 32'd42; bus.dec_mode = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("busy ready_low", 32'(bus.ready), 32'd0);
        bus.wr_en = 1'b1; bus.wr_data = 32'hDEAD; bus.dec_mode = 1'b0;
        @(negedge clk);
        bus.wr_en = 1'b0;
        checkOutput("busy seg_hold", bus.seg_data, prev);
        lat = 6;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("busy latency", 32'(lat), 32'd34);
        checkOutput("busy seg_data", bus.seg_data, 32'h00000042);

        // Reset mid-conversion aborts it without a done pulse.
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_data = 32'd555; bus.dec_mode = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("abort seg_hold", bus.seg_data, 32'h00000042);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort seg_data", bus.seg_data, 32'h0);
        checkOutput("abort ready", 32'(bus.ready), 32'd1);
        checkOutput("abort done", 32'(bus.done), 32'd0);
        doneSeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) doneSeen++;
        end
        checkOutput("abort no_done", 32'(doneSeen), 32'd0);
        applyStimulus(32'd555, 1'b1, 32'h00000555, "after_abort");

`ifdef SEG_SIGNED_EN
        applyStimulus(-32'sd42, 1'b1, 32'hF0000042, "neg42");
        applyStimulus(-32'sd10000000, 1'b1, 32'hFFFFFFFF, "neg_ovf");
        applyStimulus(-32'sd9999999, 1'b1, 32'hF9999999, "neg_max");
        applyStimulus(32'h80000000, 1'b1, 32'hFFFFFFFF, "most_neg");
        applyStimulus(32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, "hex_signed_build");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
